// File: rtl/test_pattern_generator_pkg.sv
// Shared types and helpers for the sTGC test-pattern generator.
package muon_test_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2
  } state_e;

  // Widest layer the mask helper can build.
  localparam int MAX_STRIPS = 64;

  // Number of distinct cluster positions across one layer.
  function automatic int num_positions(input int n, input int c);
    return n - c + 1;
  endfunction

  // Contiguous run of `width` ones starting at bit `pos`, clipped to `n` strips.
  function automatic logic [MAX_STRIPS-1:0] cluster_mask(input int pos, input int width, input int n);
    logic [MAX_STRIPS-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_STRIPS; b++) begin
      m[b] = (b >= pos) && (b < pos + width) && (b < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/test_pattern_generator_if.sv
// Control and detector-side signals of the test-pattern generator.
interface test_pattern_generator_if #(
  parameter int N_STRIPS = 8,
  parameter int N_EVENTS = 36
);
  localparam int EW = ($clog2(N_EVENTS) < 1) ? 1 : $clog2(N_EVENTS);

  logic                  start_i;
  logic                  stop_i;
  logic                  continuous_i;
  logic                  ramp_i;
  logic [2*N_STRIPS-1:0] signals_o;
  logic                  trigger_o;
  logic [EW-1:0]         event_idx_o;
  logic                  busy_o;
  logic                  done_o;

  // Generator side.
  modport master (
    input  start_i, stop_i, continuous_i, ramp_i,
    output signals_o, trigger_o, event_idx_o, busy_o, done_o
  );

  // Controller / consumer side.
  modport slave (
    output start_i, stop_i, continuous_i, ramp_i,
    input  signals_o, trigger_o, event_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/test_pattern_generator_trigger_delay.sv
// One-shot delay line: trig_o pulses DELAY cycles after the cycle following arm_i.
module trigger_delay #(
  parameter int DELAY = 10
) (
  input  logic clk,
  input  logic aresetn,
  input  logic arm_i,
  input  logic cancel_i,
  output logic trig_o
);
  localparam int DW = (DELAY < 1) ? 1 : $clog2(DELAY + 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          trig_q, trig_d;

  // Countdown: loaded with DELAY on arm, fires when it expires, zero means idle.
  always_comb begin
    cnt_d  = cnt_q;
    trig_d = 1'b0;
    if (cancel_i) begin
      cnt_d = '0;
    end else if (arm_i) begin
      if (DELAY == 0) trig_d = 1'b1;
      else            cnt_d  = DW'(DELAY);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - DW'(1);
      trig_d = (cnt_q == DW'(1));
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      trig_q <= trig_d;
    end
  end

  assign trig_o = trig_q;
endmodule

// File: rtl/test_pattern_generator.sv
// sTGC test-stimulus source: walks a two-layer strip cluster event by event,
// each event followed by its own delayed trigger.
module test_pattern_generator
  import muon_test_pkg::*;
#(
  parameter int N_STRIPS    = 8,
  parameter int CLUSTER     = 3,
  parameter int N_EVENTS    = 36,
  parameter int WAIT_CYCLES = 200,
  parameter int PULSE_W     = 4,
  parameter int TRIG_DELAY  = 10
) (
  input logic                      clk,
  input logic                      aresetn,
  test_pattern_generator_if.master bus
);
  localparam int P       = num_positions(N_STRIPS, CLUSTER);
  localparam int SW      = 2 * N_STRIPS;
  localparam int EW      = ($clog2(N_EVENTS) < 1) ? 1 : $clog2(N_EVENTS);
  localparam int MAX_AB  = (PULSE_W > N_EVENTS) ? PULSE_W : N_EVENTS;
  localparam int CNT_MAX = (MAX_AB > WAIT_CYCLES) ? MAX_AB : WAIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  // Ramp mode shrinks the last event to a single cycle, so that is the shortest event.
  localparam int MIN_W   = 1;
  localparam logic [EW-1:0] LAST_IDX = EW'(N_EVENTS - 1);

  if (CLUSTER < 1 || CLUSTER > N_STRIPS) begin : g_bad_cluster
    $error("CLUSTER must lie in 1..N_STRIPS");
  end
  if (N_STRIPS > MAX_STRIPS) begin : g_bad_strips
    $error("N_STRIPS exceeds MAX_STRIPS");
  end
  if (N_EVENTS < 1 || WAIT_CYCLES < 1 || PULSE_W < 1) begin : g_bad_counts
    $error("N_EVENTS, WAIT_CYCLES and PULSE_W must be at least 1");
  end
  if (TRIG_DELAY >= MIN_W + WAIT_CYCLES) begin : g_bad_delay
    $error("TRIG_DELAY must be shorter than the shortest event plus gap");
  end

  state_e        state_q, state_d;
  logic [EW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sig_q, sig_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          arm;
  logic          cancel;
  logic          trig;

  // Layer A walks down from the top every event; layer B walks up once per P events.
  function automatic logic [SW-1:0] event_mask(input logic [EW-1:0] e);
    int ei, i, j;
    logic [MAX_STRIPS-1:0] a, b;
    ei = int'(e);
    i  = ei % P;
    j  = (ei / P) % P;
    a  = cluster_mask(N_STRIPS - CLUSTER - i, CLUSTER, N_STRIPS);
    b  = cluster_mask(j, CLUSTER, N_STRIPS);
    return {b[N_STRIPS-1:0], a[N_STRIPS-1:0]};
  endfunction

  // Event width minus one, the value loaded into the countdown.
  function automatic logic [CW-1:0] event_len(input logic [EW-1:0] e, input logic ramp);
    int w;
    w = ramp ? (N_EVENTS - int'(e)) : PULSE_W;
    if (w < 1) w = 1;
    return CW'(w - 1);
  endfunction

  // Next-state logic; stop wins over every other transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;
    done_d  = 1'b0;
    arm     = 1'b0;
    cancel  = 1'b0;
    if (bus.stop_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      sig_d   = '0;
      cancel  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            state_d = EMIT;
            idx_d   = '0;
            cnt_d   = event_len(EW'(0), bus.ramp_i);
            sig_d   = event_mask(EW'(0));
            arm     = 1'b1;
          end
        end
        EMIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            sig_d = '0;
            if (idx_q == LAST_IDX) begin
              done_d = 1'b1;
              idx_d  = '0;
              if (bus.continuous_i) begin
                state_d = GAP;
                cnt_d   = CW'(WAIT_CYCLES - 1);
              end else begin
                state_d = IDLE;
                cnt_d   = '0;
              end
            end else begin
              state_d = GAP;
              idx_d   = idx_q + EW'(1);
              cnt_d   = CW'(WAIT_CYCLES - 1);
            end
          end
        end
        GAP: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = EMIT;
            cnt_d   = event_len(idx_q, bus.ramp_i);
            sig_d   = event_mask(idx_q);
            arm     = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
          sig_d   = '0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  trigger_delay #(
    .DELAY (TRIG_DELAY)
  ) u_trig (
    .clk      (clk),
    .aresetn  (aresetn),
    .arm_i    (arm),
    .cancel_i (cancel),
    .trig_o   (trig)
  );

  assign bus.signals_o   = sig_q;
  assign bus.trigger_o   = trig;
  assign bus.event_idx_o = idx_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
endmodule

// File: tb/tb_test_pattern_generator.sv
// Bench for test_pattern_generator: default build plus a small P=1 build.
module tb_test_pattern_generator;
  localparam int NA = 8, CA = 3, EA = 36, WA = 200, PA = 4, TA = 10;
  localparam int NB = 4, CB = 4, EB = 3,  WB = 5,   PB = 2, TB = 0;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic sel = 1'b0;
  always #5 clk = ~clk;

  test_pattern_generator_if #(.N_STRIPS(NA), .N_EVENTS(EA)) a_if ();
  test_pattern_generator_if #(.N_STRIPS(NB), .N_EVENTS(EB)) b_if ();

  test_pattern_generator #(
    .N_STRIPS(NA), .CLUSTER(CA), .N_EVENTS(EA),
    .WAIT_CYCLES(WA), .PULSE_W(PA), .TRIG_DELAY(TA)
  ) dut_a (.clk(clk), .aresetn(aresetn), .bus(a_if));

  test_pattern_generator #(
    .N_STRIPS(NB), .CLUSTER(CB), .N_EVENTS(EB),
    .WAIT_CYCLES(WB), .PULSE_W(PB), .TRIG_DELAY(TB)
  ) dut_b (.clk(clk), .aresetn(aresetn), .bus(b_if));

  typedef struct {
    logic [15:0] mask;
    int          w;
  } exp_t;
  exp_t exp_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, cur_w = 0, gap_cnt = 0, ev_start = 0;
  int trig_cnt = 0, done_cnt = 0, last_trig = 0;
  bit gap_valid = 1'b0;
  logic [15:0] cur_mask = '0;

  logic [15:0] m_sig;
  logic        m_trg, m_busy, m_done;
  logic [31:0] m_idx;
  assign m_sig  = sel ? {8'h00, b_if.signals_o} : a_if.signals_o;
  assign m_trg  = sel ? b_if.trigger_o : a_if.trigger_o;
  assign m_busy = sel ? b_if.busy_o    : a_if.busy_o;
  assign m_done = sel ? b_if.done_o    : a_if.done_o;
  assign m_idx  = sel ? 32'(b_if.event_idx_o) : 32'(a_if.event_idx_o);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_mask(input int n, input int c, input int e);
    int p, i, j;
    logic [15:0] run;
    p   = n - c + 1;
    i   = e % p;
    j   = (e / p) % p;
    run = (16'h1 << c) - 16'h1;
    return (run << (n - c - i)) | (run << (n + j));
  endfunction

  task automatic push_run(input int n, input int c, input int nev, input bit ramp, input int pw);
    exp_t x;
    for (int e = 0; e < nev; e++) begin
      x.mask = ref_mask(n, c, e);
      x.w    = ramp ? (nev - e) : pw;
      exp_q.push_back(x);
    end
  endtask

  task automatic push_one(input logic [15:0] mask, input int w);
    exp_t x;
    x.mask = mask;
    x.w    = w;
    exp_q.push_back(x);
  endtask

  // Monitor: times each event, its gap and its trigger, popping expected events.
  always @(negedge clk) begin
    exp_t x;
    int td, wt;
    td = sel ? TB : TA;
    wt = sel ? WB : WA;
    cyc++;
    if (m_done) done_cnt++;
    if (m_sig != 16'h0) begin
      if (cur_w == 0) begin
        if (gap_valid) chk("gap_len", 32'(gap_cnt), 32'(wt));
        gap_valid = 1'b0;
        ev_start  = cyc;
        cur_mask  = m_sig;
      end else if (m_sig != cur_mask) begin
        chk("mask_stable", 32'(m_sig), 32'(cur_mask));
      end
      cur_w++;
    end else begin
      if (cur_w != 0) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_event", 32'(cur_mask), 32'h0);
        end else begin
          x = exp_q.pop_front();
          chk("ev_mask", 32'(cur_mask), 32'(x.mask));
          chk("ev_width", 32'(cur_w), 32'(x.w));
        end
        cur_w     = 0;
        gap_valid = 1'b1;
        gap_cnt   = 0;
      end
      if (m_busy) gap_cnt++;
      else        gap_valid = 1'b0;
    end
    if (m_trg) begin
      trig_cnt++;
      last_trig = cyc;
      chk("trig_offset", 32'(cyc - ev_start), 32'(td));
    end
  end

  function automatic bit cond(input int kind);
    case (kind)
      0:       return m_done;
      1:       return m_sig != 16'h0;
      2:       return !m_busy;
      3:       return (exp_q.size() == 0) && (cur_w == 0);
      4:       return (m_sig != 16'h0) && (m_idx == 32'd3);
      default: return 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int budget, input string tag);
    int n;
    n = 0;
    while (!cond(kind) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk(tag, 32'(cond(kind)), 32'd1);
  endtask

  task automatic pulse_start(input bit b);
    if (b) b_if.start_i = 1'b1; else a_if.start_i = 1'b1;
    @(negedge clk); #1;
    b_if.start_i = 1'b0;
    a_if.start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    a_if.stop_i = 1'b1;
    @(negedge clk); #1;
    a_if.stop_i = 1'b0;
  endtask

  task automatic clear_counts();
    trig_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic full_run(input bit ramp, input int exp_len, input string tag);
    int t0, t1;
    a_if.ramp_i = ramp;
    clear_counts();
    push_run(NA, CA, EA, ramp, PA);
    pulse_start(1'b0);
    wait_for(1, 10, {tag, "_first_emit"});
    t0 = cyc;
    chk({tag, "_e0_mask"}, 32'(m_sig), 32'h07E0);
    wait_for(0, 8000, {tag, "_done_seen"});
    t1 = cyc;
    chk({tag, "_run_len"}, 32'(t1 - t0), 32'(exp_len));
    @(negedge clk); #1;
    chk({tag, "_busy_after"}, 32'(m_busy), 32'd0);
    repeat (20) @(negedge clk);
    #1;
    chk({tag, "_trig_count"}, 32'(trig_cnt), 32'(EA));
    chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    chk({tag, "_trig_after_done"}, 32'(last_trig > t1), 32'd1);
    chk({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    a_if.start_i = 1'b0; a_if.stop_i = 1'b0; a_if.continuous_i = 1'b0; a_if.ramp_i = 1'b0;
    b_if.start_i = 1'b0; b_if.stop_i = 1'b0; b_if.continuous_i = 1'b0; b_if.ramp_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_signals", 32'(a_if.signals_o), 32'h0);
    chk("rst_trigger", 32'(a_if.trigger_o), 32'h0);
    chk("rst_idx", 32'(a_if.event_idx_o), 32'h0);
    chk("rst_busy", 32'(a_if.busy_o), 32'h0);
    chk("rst_done", 32'(a_if.done_o), 32'h0);
    chk("rst_b_signals", 32'(b_if.signals_o), 32'h0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Fixed width, then ramped width.
    full_run(1'b0, EA * PA + (EA - 1) * WA, "fixed");
    full_run(1'b1, (EA * (EA + 1)) / 2 + (EA - 1) * WA, "ramp");
    a_if.ramp_i = 1'b0;

    // Stop in the first cycle of e3.
    clear_counts();
    push_run(NA, CA, 3, 1'b0, PA);
    push_one(ref_mask(NA, CA, 3), 1);
    pulse_start(1'b0);
    wait_for(4, 1000, "stopA_reach_e3");
    pulse_stop();
    chk("stopA_signals", 32'(m_sig), 32'h0);
    chk("stopA_busy", 32'(m_busy), 32'd0);
    chk("stopA_idx", 32'(m_idx), 32'd0);
    repeat (30) @(negedge clk);
    #1;
    chk("stopA_trig_count", 32'(trig_cnt), 32'd3);
    chk("stopA_no_done", 32'(done_cnt), 32'd0);
    chk("stopA_sb_empty", 32'(exp_q.size()), 32'd0);

    // Stop in the fifth gap cycle, before e0's trigger is due.
    clear_counts();
    push_one(ref_mask(NA, CA, 0), PA);
    pulse_start(1'b0);
    wait_for(1, 10, "stopB_first_emit");
    wait_for(3, 20, "stopB_e0_done");
    repeat (4) @(negedge clk);
    #1;
    pulse_stop();
    chk("stopB_signals", 32'(m_sig), 32'h0);
    chk("stopB_busy", 32'(m_busy), 32'd0);
    chk("stopB_done", 32'(m_done), 32'd0);
    repeat (30) @(negedge clk);
    #1;
    chk("stopB_trig_cancelled", 32'(trig_cnt), 32'd0);

    // Continuous: restart after done, with ignored start pulses mid-run.
    clear_counts();
    a_if.continuous_i = 1'b1;
    push_run(NA, CA, EA, 1'b0, PA);
    push_one(16'h07E0, PA);
    pulse_start(1'b0);
    repeat (1000) @(negedge clk);
    #1;
    pulse_start(1'b0);
    repeat (1500) @(negedge clk);
    #1;
    pulse_start(1'b0);
    wait_for(0, 8000, "cont_done_seen");
    a_if.continuous_i = 1'b0;
    wait_for(3, 400, "cont_e0_again");
    repeat (10) @(negedge clk);
    #1;
    chk("cont_busy_running", 32'(m_busy), 32'd1);
    pulse_stop();
    chk("cont_stopped", 32'(m_busy), 32'd0);
    chk("cont_done_count", 32'(done_cnt), 32'd1);
    chk("cont_trig_count", 32'(trig_cnt), 32'(EA + 1));

    // Small build: P=1, coincident trigger.
    sel = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    begin
      int t0, t1;
      clear_counts();
      push_run(NB, CB, EB, 1'b0, PB);
      pulse_start(1'b1);
      wait_for(1, 10, "small_first_emit");
      t0 = cyc;
      chk("small_mask", 32'(m_sig), 32'h00FF);
      wait_for(0, 200, "small_done_seen");
      t1 = cyc;
      chk("small_run_len", 32'(t1 - t0), 32'(EB * PB + (EB - 1) * WB));
      repeat (5) @(negedge clk);
      #1;
      chk("small_trig_count", 32'(trig_cnt), 32'(EB));
      chk("small_done_count", 32'(done_cnt), 32'd1);
      chk("small_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    // Asynchronous reset in the middle of an event.
    push_one(16'h00FF, 1);
    pulse_start(1'b1);
    wait_for(1, 10, "arst_emit");
    chk("arst_trig_before", 32'(b_if.trigger_o), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_signals", 32'(b_if.signals_o), 32'h0);
    chk("arst_trigger", 32'(b_if.trigger_o), 32'h0);
    chk("arst_idx", 32'(b_if.event_idx_o), 32'h0);
    chk("arst_busy", 32'(b_if.busy_o), 32'h0);
    chk("arst_done", 32'(b_if.done_o), 32'h0);
    @(negedge clk); #1;
    aresetn = 1'b1;
    wait_for(3, 5, "arst_sb_empty");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/test_pattern_generator.md
Name: test_pattern_generator

Overview:
Parametrised sTGC test-stimulus source for bench and in-FPGA self-test of the muon DAQ front end. It emits a programmable sequence of two-layer strip-cluster events, each a contiguous cluster per layer that walks across the strips event by event. Each event carries its own delayed one-cycle trigger. It supports single-shot or continuous runs, fixed or ramped pulse width, and abort. It drives the same inputs as the real detector front end: strip lines plus trigger.

Parameters:
N_STRIPS, 8, strips per layer; signals_o width is 2*N_STRIPS.
CLUSTER, 3, active strips per layer per event; 1 <= CLUSTER <= N_STRIPS.
N_EVENTS, 36, events per run; >= 1.
WAIT_CYCLES, 200, idle gap between events, in clk cycles; >= 1.
PULSE_W, 4, event width in fixed mode, in cycles; >= 1.
TRIG_DELAY, 10, cycles from the first EMIT cycle of an event to trigger_o; 0 means coincident.

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
start_i  in  1  begin run; sampled in IDLE only
stop_i  in  1  abort run; effective in any state
continuous_i  in  1  1 = restart after last event; sampled at end of run
ramp_i  in  1  1 = width (N_EVENTS - e), 0 = width PULSE_W; sampled at each event start
signals_o  out  2*N_STRIPS  [N_STRIPS-1:0] layer A, [2*N_STRIPS-1:N_STRIPS] layer B
trigger_o  out  1  one-cycle trigger pulse
event_idx_o  out  EW  current event index e; EW = max(1,$clog2(N_EVENTS))
busy_o  out  1  high whenever state != IDLE
done_o  out  1  one-cycle pulse after the last event of a completed run

Behaviour:
- Reset (aresetn=0, async): state=IDLE; signals_o, trigger_o, event_idx_o, busy_o, done_o all 0; all counters 0.
- Positions per layer: P = N_STRIPS-CLUSTER+1. For event e: i = e mod P; j = (e/P) mod P.
- Layer A mask: bits [N_STRIPS-1-i : N_STRIPS-CLUSTER-i] set. The cluster starts at the top and moves down by 1 each event.
- Layer B mask: bits [N_STRIPS+j+CLUSTER-1 : N_STRIPS+j] set. The cluster starts at the bottom and moves up by 1 every P events.
- If N_EVENTS > P*P, the pattern wraps through the mod.
- FSM states: IDLE, EMIT, GAP. All outputs are registered.
- IDLE: start_i=1 and stop_i=0 -> EMIT next cycle with e=0. On that first EMIT cycle signals_o already shows the event-0 mask.
- EMIT: signals_o holds mask(e) for exactly W(e) cycles. W(e) = PULSE_W, or N_EVENTS-e when ramp_i=1 (minimum 1). ramp_i is latched on the first cycle of each event.
- After W(e) cycles, if e < N_EVENTS-1: go to GAP and increment e.
- After W(e) cycles, if e = N_EVENTS-1: done_o=1 for 1 cycle. Then, if continuous_i=1, go to GAP with e=0; otherwise go to IDLE with e=0.
- GAP: signals_o = 0 for exactly WAIT_CYCLES cycles, then EMIT.
- stop_i=1 in any state -> IDLE next cycle. signals_o is cleared, any pending trigger is cancelled, and done_o is not pulsed. stop_i has priority over start_i and over every other transition.
- start_i while busy_o=1 is ignored.
- Trigger: each EMIT entry arms a delay counter. trigger_o=1 for exactly 1 cycle, TRIG_DELAY cycles after the first EMIT cycle of the event. The counter keeps running through GAP if needed.
- Elaboration check (assertion): TRIG_DELAY < min W + WAIT_CYCLES, so there is at most one pending trigger.
- Exactly one trigger per event, including the last event; the trigger may fire after done_o or in IDLE.
- Counter widths are sized from the parameters with $clog2(max+1); no counter may overflow at the maximum parameter values.

Decomposition:
- Package muon_test_pkg:
  - state enum (IDLE, EMIT, GAP)
  - function cluster_mask(pos, width, n) returning an N_STRIPS-bit mask
  - localparam helper for P
- Sub-module trigger_delay: a one-shot delay line.
  - Ports: clk, aresetn, arm_i, cancel_i, trig_o; parameter DELAY.
  - Replaces the previous edge-detector + trigger-emitter pair.

Test Plan:
1. Defaults, ramp_i=0, start_i pulse -> 36 events. e0=16'h07E0, e1=16'h0770, e5=16'h0707, e6=16'h0EE0, e35=16'hE007. Each event is 4 cycles high then 200 cycles low. done_o pulses once, then busy_o=0.
2. Defaults, ramp_i=1 -> e0 high 36 cycles, e35 high 1 cycle. Total run = sum(1..36) + 35*200 = 7666 cycles from first EMIT cycle to done_o.
3. Trigger timing, TRIG_DELAY=10 and TRIG_DELAY=0 -> trigger_o occurs at first EMIT cycle +10 (resp. +0), 36 single-cycle pulses total. Also check the last trigger after done_o.
4. stop_i asserted during EMIT of e3 and in the 5th GAP cycle -> next cycle: signals_o=0, busy_o=0, event_idx_o=0, no done_o, no further trigger.
5. continuous_i=1 -> after done_o, a 200-cycle gap, then e0=16'h07E0 again. start_i pulses mid-run have no effect.
6. N_STRIPS=4, CLUSTER=4, N_EVENTS=3 -> P=1 and every event = 8'hFF. aresetn asserted mid-EMIT -> all outputs 0 immediately, without waiting for a clk edge.
